// File: rtl/dvi_transmitter_pkg.sv
// Shared constants and helpers for the DVI TMDS transmitter: control tokens,
// clock-channel pattern, disparity counter width and the stage-1 encoding.
package dvi_transmitter_pkg;

  localparam int CNT_W = 5;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [9:0] CLK_PATTERN = 10'b1111100000;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
    logic [9:0] tok;
    case ({c1, c0})
      2'b00:   tok = CTRL_TOKEN_00;
      2'b01:   tok = CTRL_TOKEN_01;
      2'b10:   tok = CTRL_TOKEN_10;
      default: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

  // Transition-minimising stage: q_m[8]=1 marks the XOR chain, 0 the XNOR chain.
  function automatic logic [8:0] tmds_minimise(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n;
    logic       use_xnor;
    n        = ones8(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

endpackage

// File: rtl/dvi_transmitter_tmds_encoder.sv
// One TMDS channel: stage 1 registers the transition-minimised word and the
// de/control bits, stage 2 applies DC balancing and registers the symbol.
module tmds_encoder
  import dvi_transmitter_pkg::*;
(
  input  logic       pclk,
  input  logic       reset,
  input  logic [7:0] d,
  input  logic       de,
  input  logic       c0,
  input  logic       c1,
  output logic [9:0] tmds
);

  localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

  logic [8:0]              q_m;
  logic                    de_q;
  logic                    c0_q;
  logic                    c1_q;
  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_nxt;
  logic signed [CNT_W-1:0] diff;
  logic [9:0]              tmds_nxt;
  logic                    q8;
  logic [7:0]              qd;
  logic                    cnt_pos;
  logic                    cnt_neg;
  logic                    diff_pos;
  logic                    diff_neg;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      q_m  <= '0;
      de_q <= 1'b0;
      c0_q <= 1'b0;
      c1_q <= 1'b0;
    end else begin
      q_m  <= tmds_minimise(d);
      de_q <= de;
      c0_q <= c0;
      c1_q <= c1;
    end
  end

  assign q8 = q_m[8];
  assign qd = q_m[7:0];

  // n1 - n0 = 2*n1 - 8; the 5-bit wrap of 2*n1 = 16 still yields +8.
  assign diff     = $signed({ones8(qd), 1'b0} - CNT_W'(8));
  assign cnt_neg  = cnt[CNT_W-1];
  assign cnt_pos  = !cnt[CNT_W-1] && (cnt != '0);
  assign diff_neg = diff[CNT_W-1];
  assign diff_pos = !diff[CNT_W-1] && (diff != '0);

  always_comb begin
    tmds_nxt = {1'b0, q8, qd};
    cnt_nxt  = cnt;
    if (!de_q) begin
      tmds_nxt = ctrl_token(c1_q, c0_q);
      cnt_nxt  = '0;
    end else if ((cnt == '0) || (diff == '0)) begin
      tmds_nxt = {~q8, q8, (q8 ? qd : ~qd)};
      cnt_nxt  = q8 ? (cnt + diff) : (cnt - diff);
    end else if ((cnt_pos && diff_pos) || (cnt_neg && diff_neg)) begin
      tmds_nxt = {1'b1, q8, ~qd};
      cnt_nxt  = cnt - diff + (q8 ? TWO : '0);
    end else begin
      tmds_nxt = {1'b0, q8, qd};
      cnt_nxt  = cnt + diff - (q8 ? '0 : TWO);
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      tmds <= '0;
      cnt  <= '0;
    end else begin
      tmds <= tmds_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/dvi_transmitter_top.sv
// DVI TMDS transmitter core: three channel encoders (B, G, R) plus the
// constant clock-channel word. Serialisation and clocking live elsewhere.
module dvi_transmitter_top
  import dvi_transmitter_pkg::*;
(
  input  logic        pclk,
  input  logic        reset,
  input  logic [23:0] video_din,
  input  logic        video_hsync,
  input  logic        video_vsync,
  input  logic        video_de,
  output logic [9:0]  tmds_ch0,
  output logic [9:0]  tmds_ch1,
  output logic [9:0]  tmds_ch2,
  output logic [9:0]  tmds_clk_word
);

  assign tmds_clk_word = CLK_PATTERN;

  // Only the blue channel carries sync; the others send the 00 token in blanking.
  tmds_encoder u_enc_b (
    .pclk  (pclk),
    .reset (reset),
    .d     (video_din[7:0]),
    .de    (video_de),
    .c0    (video_hsync),
    .c1    (video_vsync),
    .tmds  (tmds_ch0)
  );

  tmds_encoder u_enc_g (
    .pclk  (pclk),
    .reset (reset),
    .d     (video_din[15:8]),
    .de    (video_de),
    .c0    (1'b0),
    .c1    (1'b0),
    .tmds  (tmds_ch1)
  );

  tmds_encoder u_enc_r (
    .pclk  (pclk),
    .reset (reset),
    .d     (video_din[23:16]),
    .de    (video_de),
    .c0    (1'b0),
    .c1    (1'b0),
    .tmds  (tmds_ch2)
  );

endmodule

// File: tb/tb_dvi_transmitter_top.sv
// Bench for dvi_transmitter_top: directed control/data vectors, reset cases
// and a long random run checked against a symbol-level TMDS model.
module tb_dvi_transmitter_top;

  logic        pclk;
  logic        rst;
  logic [23:0] din;
  logic        de;
  logic        hs;
  logic        vs;
  logic [9:0]  ch0;
  logic [9:0]  ch1;
  logic [9:0]  ch2;
  logic [9:0]  clk_word;

  int n_checks = 0;
  int n_fail   = 0;

  // Entry layout: {de, din[23:0], sym_ch2, sym_ch1, sym_ch0}
  logic [54:0] exp_q[$];
  int          m_cnt[3];
  int          d_cnt[3];
  logic [9:0]  tok[4];
  logic [9:0]  s_exp[3];
  logic [9:0]  act[3];
  logic [54:0] e;
  int          nc;

  dvi_transmitter_top u_dut (
    .pclk          (pclk),
    .reset         (rst),
    .video_din     (din),
    .video_hsync   (hs),
    .video_vsync   (vs),
    .video_de      (de),
    .tmds_ch0      (ch0),
    .tmds_ch1      (ch1),
    .tmds_ch2      (ch2),
    .tmds_clk_word (clk_word)
  );

  // Clock
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, actual, expected);
    end
  endtask

  // Symbol-level model: q_m bit i is the parity of d[0..i], flipped on odd
  // bits for the XNOR chain; disparity is ones minus zeros of the 10-bit symbol.
  function automatic logic [9:0] model_data(input logic [7:0] d, input int cnt_in, output int cnt_out);
    int         ones;
    int         n1;
    logic       xm;
    logic       inv;
    logic       q8;
    logic [7:0] q;
    logic [7:0] mask;
    logic [9:0] sym;
    ones = $countones(d);
    xm   = (ones > 4) || ((ones == 4) && !d[0]);
    for (int i = 0; i < 8; i++) begin
      mask = 8'hFF >> (7 - i);
      q[i] = (^(d & mask)) ^ (xm && (i % 2 == 1));
    end
    q8 = !xm;
    n1 = $countones(q);
    if ((cnt_in == 0) || (n1 == 4)) inv = !q8;
    else inv = ((cnt_in > 0) && (n1 > 4)) || ((cnt_in < 0) && (n1 < 4));
    sym     = {inv, q8, (inv ? ~q : q)};
    cnt_out = cnt_in + 2 * $countones(sym) - 10;
    return sym;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] sym);
    logic [7:0] v;
    logic [7:0] d;
    v    = sym[9] ? ~sym[7:0] : sym[7:0];
    d[0] = v[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = sym[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    end
    return d;
  endfunction

  task automatic drive(input logic d_e, input logic h, input logic v, input logic [23:0] px);
    de  = d_e;
    hs  = h;
    vs  = v;
    din = px;
    @(negedge pclk);
  endtask

  // Scoreboard: model each sampled pixel, compare two edges later.
  always @(posedge pclk) begin
    if (rst) begin
      exp_q.delete();
      for (int c = 0; c < 3; c++) begin
        m_cnt[c] = 0;
        d_cnt[c] = 0;
      end
      #1;
      check("ch0 in reset", ch0, 10'b0);
      check("ch1 in reset", ch1, 10'b0);
      check("ch2 in reset", ch2, 10'b0);
    end else begin
      if (de) begin
        for (int c = 0; c < 3; c++) begin
          s_exp[c] = model_data(din[8*c +: 8], m_cnt[c], nc);
          m_cnt[c] = nc;
        end
      end else begin
        s_exp[0] = tok[{vs, hs}];
        s_exp[1] = tok[0];
        s_exp[2] = tok[0];
        for (int c = 0; c < 3; c++) m_cnt[c] = 0;
      end
      exp_q.push_back({de, din, s_exp[2], s_exp[1], s_exp[0]});
      #1;
      check("clk word", clk_word, 10'b1111100000);
      if (exp_q.size() >= 2) begin
        e      = exp_q.pop_front();
        act[0] = ch0;
        act[1] = ch1;
        act[2] = ch2;
        for (int c = 0; c < 3; c++) begin
          check($sformatf("ch%0d symbol", c), act[c], e[10*c +: 10]);
          if (e[54]) begin
            check($sformatf("ch%0d decode", c), decode(act[c]), e[30 + 8*c +: 8]);
            d_cnt[c] = d_cnt[c] + 2 * $countones(act[c]) - 10;
            n_checks++;
            if ((d_cnt[c] > 8) || (d_cnt[c] < -8)) begin
              n_fail++;
              $display("FAIL ch%0d disparity: got %0d required within -8..8", c, d_cnt[c]);
            end
          end else begin
            d_cnt[c] = 0;
          end
        end
      end
    end
  end

  initial begin
    int         pc;
    int         run;
    logic       rde;
    logic [9:0] ps;

    rst = 1'b1;
    din = '0;
    de  = 1'b0;
    hs  = 1'b0;
    vs  = 1'b0;
    tok[0] = 10'b1101010100;
    tok[1] = 10'b0010101011;
    tok[2] = 10'b0101010100;
    tok[3] = 10'b1010101011;

    // Pin the model against hand-computed symbols
    ps = model_data(8'h00, 0, pc);
    check("model 00 sym", ps, 10'b0100000000);
    check("model 00 cnt", pc, -8);
    ps = model_data(8'h00, -8, pc);
    check("model 00 second sym", ps, 10'b1111111111);
    check("model 00 second cnt", pc, 2);
    ps = model_data(8'hFF, 0, pc);
    check("model FF sym", ps, 10'b1000000000);
    ps = model_data(8'h10, 0, pc);
    check("model 10 sym", ps, 10'b0111110000);

    repeat (2) @(negedge pclk);
    check("reset ch0", ch0, 10'b0);
    check("reset ch1", ch1, 10'b0);
    check("reset ch2", ch2, 10'b0);
    check("reset clk word", clk_word, 10'b1111100000);
    rst = 1'b0;

    // Control periods
    repeat (3) drive(1'b0, 1'b1, 1'b0, 24'h0);
    check("ctrl hs ch0", ch0, 10'b0010101011);
    check("ctrl hs ch1", ch1, 10'b1101010100);
    check("ctrl hs ch2", ch2, 10'b1101010100);
    repeat (3) drive(1'b0, 1'b0, 1'b1, 24'h0);
    check("ctrl vs ch0", ch0, 10'b0101010100);
    repeat (3) drive(1'b0, 1'b1, 1'b1, 24'h0);
    check("ctrl hs vs ch0", ch0, 10'b1010101011);

    // Two blue 0x00 pixels from cnt=0
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    check("B00 first ch0", ch0, 10'b0100000000);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    check("B00 second ch0", ch0, 10'b1111111111);
    drive(1'b0, 1'b0, 1'b0, 24'h0);

    // Blue 0xFF from cnt=0
    drive(1'b1, 1'b0, 1'b0, 24'h0000FF);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    check("BFF ch0", ch0, 10'b1000000000);
    drive(1'b0, 1'b0, 1'b0, 24'h0);

    // Single-cycle de pulse on green
    drive(1'b1, 1'b0, 1'b0, 24'h001000);
    check("pulse pre ch1", ch1, 10'b1101010100);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    check("pulse data ch1", ch1, 10'b0111110000);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    check("pulse post ch1", ch1, 10'b1101010100);
    drive(1'b0, 1'b0, 1'b0, 24'h0);

    // Reset during active video
    repeat (4) drive(1'b1, 1'b0, 1'b0, 24'h555555);
    rst = 1'b1;
    #1;
    check("midreset ch0", ch0, 10'b0);
    check("midreset ch1", ch1, 10'b0);
    check("midreset ch2", ch2, 10'b0);
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    check("post reset ch0", ch0, 10'b0100000000);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 24'h0);

    // Random pixels with de runs
    run = 0;
    rde = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (run == 0) begin
        rde = !rde;
        run = int'($urandom_range(1, 40));
      end
      run--;
      drive(rde, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom));
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dvi_transmitter_top.md
DVI_TRANSMITTER_TOP -- requirements
Module: dvi_transmitter_top

Interface
REQ-001 The block SHALL have no parameters; all widths and constants are fixed.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 pclk  input  1  pixel clock; all logic is clocked on its rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 video_din  input  24  RGB888 pixel: [23:16]=R, [15:8]=G, [7:0]=B.
REQ-006 video_hsync  input  1  horizontal sync, carried on channel 0 as C0.
REQ-007 video_vsync  input  1  vertical sync, carried on channel 0 as C1.
REQ-008 video_de  input  1  data enable: 1 = active pixel, 0 = blanking/control period.
REQ-009 tmds_ch0  output  10  channel 0 (Blue) TMDS symbol; bit 0 is transmitted first.
REQ-010 tmds_ch1  output  10  channel 1 (Green) TMDS symbol.
REQ-011 tmds_ch2  output  10  channel 2 (Red) TMDS symbol.
REQ-012 tmds_clk_word  output  10  clock-channel pattern.

Function
REQ-013 Each channel SHALL encode per DVI 1.0 TMDS.
- Stage 1, minimise transitions. Let n1d = number of ones in D.
  - If n1d>4, or n1d==4 with D[0]==0: XNOR chain, q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
  - In both cases q_m[0]=D[0].
REQ-014 Stage 2, DC balance, using signed 5-bit running disparity cnt. n1/n0 = ones/zeros in q_m[7:0].
- If cnt==0 or n1==n0:
  - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
  - cnt += q_m[8] ? (n1-n0) : (n0-n1).
- Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
  - out = {1, q_m[8], ~q_m[7:0]}.
  - cnt += 2*q_m[8] + (n0-n1).
- Else:
  - out = {0, q_m[8], q_m[7:0]}.
  - cnt += -2*(~q_m[8]) + (n1-n0).
REQ-015 When video_de=0, each channel SHALL output a control token from {C1,C0}:
- 00 -> 1101010100
- 01 -> 0010101011
- 10 -> 0101010100
- 11 -> 1010101011
- cnt is cleared to 0 at the same time.
REQ-016 Channel 0 SHALL use C0=video_hsync and C1=video_vsync; channels 1 and 2 SHALL use C1=C0=0.
REQ-017 Inputs SHALL be registered on the first edge (stage 1). tmds_chN SHALL be registered on the second edge. Total latency is 2 pclk; throughput is 1 symbol per pclk.
REQ-018 video_de, hsync and vsync SHALL be delayed alongside the data so each symbol matches its own pixel's de/sync.
REQ-019 tmds_clk_word SHALL be the constant 1111100000.
REQ-020 cnt arithmetic SHALL be two's complement, 5-bit; the DVI algorithm bounds it to -8..+8, so it never wraps.
REQ-021 A de transition SHALL take effect on exactly the symbol of that pixel, with no gap or extra symbol.

Reset
REQ-022 While reset=1, all pipeline registers and every cnt SHALL be 0, and tmds_ch0/1/2 SHALL be 0000000000.
REQ-023 tmds_clk_word SHALL be 1111100000 regardless of reset.
REQ-024 On reset deassertion, valid symbols SHALL appear 2 pclk after the first sampled input.
REQ-025 Reset asserted mid-line SHALL clear cnt immediately; encoding restarts with cnt=0.

Structure
REQ-026 A shared package SHALL hold:
- the four control-token constants;
- the clock pattern 1111100000;
- the cnt width (5).
REQ-027 A sub-module tmds_encoder SHALL implement REQ-013..REQ-015 and be instantiated three times: B->ch0, G->ch1, R->ch2.
REQ-028 Serialization, differential output buffers, and the pll_0/pll_1 clock generation (pixel clock and 5x clock) SHALL be outside this block.

Verification
REQ-029 Control periods, de=0, held 3 cycles, checked 2 cycles later:
- hs=1, vs=0 -> ch0=0010101011; ch1=ch2=1101010100.
- hs=0, vs=1 -> ch0=0101010100.
- hs=1, vs=1 -> ch0=1010101011.
REQ-030 de=1, B=0x00 on consecutive cycles from cnt=0:
- 1st symbol: ch0=0100000000, cnt becomes -8.
- 2nd symbol: ch0=1111111111, cnt becomes +2.
REQ-031 de=1, B=0xFF from cnt=0 -> ch0=1000000000, cnt becomes -8.
REQ-032 Random 10,000 pixels with de toggling, checked against a reference model:
- decoding every symbol returns the original byte;
- |cnt| never exceeds 8;
- cnt is 0 after each blanking symbol.
REQ-033 Reset mid-frame: assert reset during active video -> outputs go to 0 the same cycle (async); after release, the first symbol of a 0x00 pixel is 0100000000.
REQ-034 Latency check: single-cycle de=1 pulse with G=0x10 -> exactly one data symbol on ch1, appearing at cycle+2 and flanked by control tokens.
